// File: rtl/lora_pkt_pkg.sv
// Shared types and constants for the LoRa energy gate: FSM states, IQ field
// layout, default burst/packet lengths and the per-sample power helper.
package lora_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HANG   = 2'd2
    } egate_state_t;

    localparam int IQ_W         = 16;
    localparam int I_LSB        = 16;
    localparam int Q_LSB        = 0;
    localparam int PWR_W        = 32;
    localparam int PKT_LEN_DEF  = 256;
    localparam int HANG_LEN_DEF = 256;

    // I*I + Q*Q peaks at 2^31 (both at -32768), so 32 unsigned bits never overflow
    function automatic logic [PWR_W-1:0] iq_power(input logic [31:0] sample);
        logic signed [IQ_W-1:0]  i_v;
        logic signed [IQ_W-1:0]  q_v;
        logic signed [PWR_W-1:0] ii_v;
        logic signed [PWR_W-1:0] qq_v;
        i_v  = sample[I_LSB +: IQ_W];
        q_v  = sample[Q_LSB +: IQ_W];
        ii_v = 32'(i_v) * 32'(i_v);
        qq_v = 32'(q_v) * 32'(q_v);
        return $unsigned(ii_v) + $unsigned(qq_v);
    endfunction

endpackage

// File: rtl/lora_pwr_window.sv
// Sliding-window power average: per-sample power, history shift register and
// running sum. avg reflects the sum including the sample currently offered.
module lora_pwr_window
    import lora_pkt_pkg::*;
#(
    parameter int WIN_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [31:0]               sample,
    output logic [PWR_W+WIN_LOG2-1:0] avg
);

    localparam int WIN   = 1 << WIN_LOG2;
    localparam int SUM_W = PWR_W + WIN_LOG2;

    logic [PWR_W-1:0] hist_r [WIN];
    logic [SUM_W-1:0] sum_r;
    logic [SUM_W-1:0] sum_nxt_s;
    logic [PWR_W-1:0] pwr_s;

    // new sum adds the incoming power and retires the oldest history entry
    always_comb begin
        pwr_s     = iq_power(sample);
        sum_nxt_s = sum_r + SUM_W'(pwr_s) - SUM_W'(hist_r[WIN-1]);
        avg       = sum_nxt_s >> WIN_LOG2;
    end

    // history and sum advance only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
            for (int k = 0; k < WIN; k++) begin
                hist_r[k] <= '0;
            end
        end else if (en) begin
            sum_r     <= sum_nxt_s;
            hist_r[0] <= pwr_s;
            for (int k = 1; k < WIN; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

endmodule

// File: rtl/lora_energy_gate.sv
// Energy-detect gate: forwards IQ bursts whose window-average power crosses a
// threshold, with hang time and TLAST packetisation. Macro LORA_EGATE_STATS_EN enables counters.
module lora_energy_gate
    import lora_pkt_pkg::*;
#(
    parameter int WIN_LOG2 = 5,
    parameter int HANG_LEN = HANG_LEN_DEF,
    parameter int PKT_LEN  = PKT_LEN_DEF
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [31:0] data_in_TDATA,
    input  logic        data_in_TVALID,
    output logic        data_in_TREADY,
    input  logic        data_in_TLAST,
    output logic [31:0] data_out_TDATA,
    output logic        data_out_TVALID,
    input  logic        data_out_TREADY,
    output logic        data_out_TLAST,
    input  logic [31:0] power_threshold_in_V,
    output logic        det_active_V,
    output logic [31:0] burst_count_V,
    output logic [31:0] drop_count_V
);

    localparam int SUM_W = PWR_W + WIN_LOG2;

    egate_state_t     state_r, state_nxt_s;
    logic [31:0]      hang_r, hang_nxt_s;
    logic [31:0]      pkt_r, pkt_nxt_s;
    logic [31:0]      out_data_r;
    logic             out_valid_r, out_last_r, det_active_r;
    logic             accept_s, hot_s, fwd_s, last_s, burst_end_s;
    logic [SUM_W-1:0] avg_s;
    logic             unused_tlast_s;

    assign unused_tlast_s  = data_in_TLAST;
    assign data_in_TREADY  = !out_valid_r || data_out_TREADY;
    assign accept_s        = data_in_TVALID && data_in_TREADY;
    assign hot_s           = (avg_s >= SUM_W'(power_threshold_in_V));
    assign data_out_TDATA  = out_data_r;
    assign data_out_TVALID = out_valid_r;
    assign data_out_TLAST  = out_last_r;
    assign det_active_V    = det_active_r;

    lora_pwr_window #(.WIN_LOG2(WIN_LOG2)) u_pwr (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .en     (accept_s),
        .sample (data_in_TDATA),
        .avg    (avg_s)
    );

    // next state, hang countdown and packet position for the offered sample
    always_comb begin
        state_nxt_s = state_r;
        hang_nxt_s  = hang_r;
        fwd_s       = 1'b0;
        burst_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hot_s) begin
                    state_nxt_s = ST_ACTIVE;
                    fwd_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                fwd_s = 1'b1;
                if (!hot_s) begin
                    state_nxt_s = ST_HANG;
                    hang_nxt_s  = 32'(HANG_LEN - 1);
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_HANG: begin
                fwd_s = 1'b1;
                // renewed energy wins over an expiring hang count
                if (hot_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (hang_r == 32'd0) begin
                    state_nxt_s = ST_IDLE;
                    burst_end_s = 1'b1;
                end else begin
                    hang_nxt_s  = hang_r - 32'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        last_s = fwd_s && (burst_end_s || (pkt_r == 32'(PKT_LEN - 1)));
        if (!fwd_s) begin
            pkt_nxt_s = pkt_r;
        end else if (last_s) begin
            pkt_nxt_s = 32'd0;
        end else begin
            pkt_nxt_s = pkt_r + 32'd1;
        end
    end

    // FSM and burst bookkeeping registers; frozen while the output stalls
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r      <= ST_IDLE;
            hang_r       <= 32'd0;
            pkt_r        <= 32'd0;
            det_active_r <= 1'b0;
        end else if (accept_s) begin
            state_r      <= state_nxt_s;
            hang_r       <= hang_nxt_s;
            pkt_r        <= pkt_nxt_s;
            det_active_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // output register holds its beat until the consumer takes it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 32'd0;
        end else if (accept_s) begin
            out_valid_r <= fwd_s;
            out_last_r  <= last_s;
            if (fwd_s) begin
                out_data_r <= data_in_TDATA;
            end
        end else if (data_out_TREADY) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef LORA_EGATE_STATS_EN
    logic [31:0] burst_cnt_r, drop_cnt_r;

    // a non-forwarded accepted sample can only be an IDLE discard
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            burst_cnt_r <= 32'd0;
            drop_cnt_r  <= 32'd0;
        end else if (accept_s) begin
            if (burst_end_s) begin
                burst_cnt_r <= burst_cnt_r + 32'd1;
            end
            if (!fwd_s) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end
        end
    end

    assign burst_count_V = burst_cnt_r;
    assign drop_count_V  = drop_cnt_r;
`else
    assign burst_count_V = 32'd0;
    assign drop_count_V  = 32'd0;
`endif

endmodule

// File: tb/tb_lora_energy_gate.sv
// Scoreboard bench for lora_energy_gate: directed bursts, backpressure, hang
// resume, zero threshold and mid-burst reset, with hand-derived burst shapes.
module tb_lora_energy_gate;

`ifdef LORA_EGATE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] data_in_TDATA = 32'd0;
    logic        data_in_TVALID = 1'b0;
    logic        data_in_TREADY;
    logic        data_in_TLAST = 1'b0;
    logic [31:0] data_out_TDATA;
    logic        data_out_TVALID;
    logic        data_out_TREADY = 1'b1;
    logic        data_out_TLAST;
    logic [31:0] power_threshold_in_V = 32'd0;
    logic        det_active_V;
    logic [31:0] burst_count_V;
    logic [31:0] drop_count_V;

    lora_energy_gate dut (
        .ap_clk               (ap_clk),
        .ap_rst_n             (ap_rst_n),
        .data_in_TDATA        (data_in_TDATA),
        .data_in_TVALID       (data_in_TVALID),
        .data_in_TREADY       (data_in_TREADY),
        .data_in_TLAST        (data_in_TLAST),
        .data_out_TDATA       (data_out_TDATA),
        .data_out_TVALID      (data_out_TVALID),
        .data_out_TREADY      (data_out_TREADY),
        .data_out_TLAST       (data_out_TLAST),
        .power_threshold_in_V (power_threshold_in_V),
        .det_active_V         (det_active_V),
        .burst_count_V        (burst_count_V),
        .drop_count_V         (drop_count_V)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { logic [31:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    int   tlast_q[$];
    int   n_out = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   bp_en = 1'b0;
    bit   ready_force = 1'b1;

    // reference model state (window of 32, hang 256, packet 256)
    longint m_hist [32];
    int     m_state, m_hang, m_pkt;

    // output-ready driver: toggles under backpressure, else follows ready_force
    initial forever begin
        @(posedge ap_clk);
        #2;
        if (bp_en) data_out_TREADY = !data_out_TREADY;
        else       data_out_TREADY = ready_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int v);
        return STATS_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_hist[k] = 0;
        m_state = 0;
        m_hang  = 0;
        m_pkt   = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [15:0] i, input logic [15:0] q);
        longint p, s;
        bit hot, fwd, bend, last;
        exp_t e;
        p = longint'($signed(i)) * longint'($signed(i)) + longint'($signed(q)) * longint'($signed(q));
        for (int k = 31; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = p;
        s = 0;
        for (int k = 0; k < 32; k++) s += m_hist[k];
        hot  = (s / 32) >= longint'(power_threshold_in_V);
        fwd  = 1'b0;
        bend = 1'b0;
        if (m_state == 0) begin
            if (hot) begin m_state = 1; fwd = 1'b1; end
        end else if (m_state == 1) begin
            fwd = 1'b1;
            if (!hot) begin m_state = 2; m_hang = 255; end
        end else begin
            fwd = 1'b1;
            if (hot) m_state = 1;
            else if (m_hang == 0) begin m_state = 0; bend = 1'b1; end
            else m_hang--;
        end
        if (fwd) begin
            last = bend || (m_pkt == 255);
            e.d = {i, q};
            e.l = last;
            exp_q.push_back(e);
            m_pkt = last ? 0 : m_pkt + 1;
        end
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q);
        int guard = 0;
        data_in_TDATA  = {i, q};
        data_in_TVALID = 1'b1;
        @(negedge ap_clk);
        while (!data_in_TREADY && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no TREADY, expected TREADY within 100 cycles");
        end else begin
            model_accept(i, q);
        end
        @(posedge ap_clk);
        #1;
        data_in_TVALID = 1'b0;
    endtask

    task automatic clear_trace();
        n_out = 0;
        tlast_q.delete();
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge ap_clk);
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_trace(input string name, input int nout, input int nl,
                               input int p0, input int p1, input int p2);
        int pos [3];
        pos[0] = p0; pos[1] = p1; pos[2] = p2;
        check({name, "_beats"}, 64'(n_out), 64'(nout));
        check({name, "_tlasts"}, 64'(tlast_q.size()), 64'(nl));
        for (int k = 0; k < nl && k < tlast_q.size(); k++)
            check($sformatf("%s_tlast%0d", name, k), 64'(tlast_q[k]), 64'(pos[k]));
    endtask

    // monitor: scoreboard pop on each transfer, stability check on each stall
    initial begin
        bit          hold_v = 1'b0;
        logic [31:0] hold_d = 32'd0;
        logic        hold_l = 1'b0;
        exp_t        e;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    n_vec++;
                    if ({data_out_TVALID, data_out_TDATA, data_out_TLAST} !== {1'b1, hold_d, hold_l}) begin
                        n_err++;
                        $display("FAIL stall_hold: got v=%b %h/%b, expected v=1 %h/%b",
                                 data_out_TVALID, data_out_TDATA, data_out_TLAST, hold_d, hold_l);
                    end
                end
                if (data_out_TVALID && data_out_TREADY) begin
                    n_out++;
                    if (data_out_TLAST) tlast_q.push_back(n_out);
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got %h/%b, expected no output", data_out_TDATA, data_out_TLAST);
                    end else begin
                        e = exp_q.pop_front();
                        if ({data_out_TDATA, data_out_TLAST} !== {e.d, e.l}) begin
                            n_err++;
                            $display("FAIL beat%0d: got %h/%b, expected %h/%b", n_out, data_out_TDATA, data_out_TLAST, e.d, e.l);
                        end
                    end
                end
                hold_v = data_out_TVALID && !data_out_TREADY;
                hold_d = data_out_TDATA;
                hold_l = data_out_TLAST;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge ap_clk);
        check("rst_valid", 64'(data_out_TVALID), 64'd0);
        check("rst_last", 64'(data_out_TLAST), 64'd0);
        check("rst_data", 64'(data_out_TDATA), 64'd0);
        check("rst_det", 64'(det_active_V), 64'd0);
        check("rst_burst", 64'(burst_count_V), 64'd0);
        check("rst_drop", 64'(drop_count_V), 64'd0);
        check("rst_ready", 64'(data_in_TREADY), 64'd1);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // silence below threshold: everything dropped
        power_threshold_in_V = 32'd1;
        clear_trace();
        repeat (20) send(16'd0, 16'd0);
        drain("quiet");
        check("quiet_beats", 64'(n_out), 64'd0);
        check("quiet_drop", 64'(drop_count_V), 64'(cnt(20)));
        check("quiet_det", 64'(det_active_V), 64'd0);

        // single burst: opens on loud #4, 97+28+1+256 = 382 beats
        power_threshold_in_V = 32'h100;
        clear_trace();
        repeat (32) send(16'd0, 16'd0);
        repeat (3) send(16'h20, 16'h20);
        check("burst_det_pre", 64'(det_active_V), 64'd0);
        check("burst_drop_pre", 64'(drop_count_V), 64'(cnt(55)));
        send(16'h20, 16'h20);
        check("burst_det_open", 64'(det_active_V), 64'd1);
        check("burst_drop_open", 64'(drop_count_V), 64'(cnt(55)));
        repeat (96) send(16'h20, 16'h20);
        repeat (300) send(16'd0, 16'd0);
        drain("burst");
        check_trace("burst", 382, 2, 256, 382, 0);
        check("burst_det_end", 64'(det_active_V), 64'd0);
        check("burst_count1", 64'(burst_count_V), 64'(cnt(1)));
        check("burst_drop", 64'(drop_count_V), 64'(cnt(70)));

        // backpressured burst, loud again when hang_cnt is 10
        bp_en = 1'b1;
        clear_trace();
        repeat (100) send(16'h20, 16'h20);
        repeat (274) send(16'd0, 16'd0);
        repeat (40) send(16'h20, 16'h20);
        repeat (300) send(16'd0, 16'd0);
        drain("resume");
        bp_en = 1'b0;
        check_trace("resume", 696, 3, 256, 512, 696);
        check("resume_count", 64'(burst_count_V), 64'(cnt(2)));
        check("resume_drop", 64'(drop_count_V), 64'(cnt(88)));

        // zero threshold: always active, packet-only TLASTs
        power_threshold_in_V = 32'd0;
        clear_trace();
        for (int k = 0; k < 600; k++) send(16'(k), 16'(~k));
        drain("thr0");
        check_trace("thr0", 600, 2, 256, 512, 0);
        check("thr0_count", 64'(burst_count_V), 64'(cnt(2)));
        check("thr0_det", 64'(det_active_V), 64'd1);

        // reset with a stalled beat in flight, then a clean burst
        ready_force = 1'b0;
        @(posedge ap_clk);
        #3;
        send(16'h1234, 16'h5678);
        @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(data_out_TVALID), 64'd0);
        check("mrst_last", 64'(data_out_TLAST), 64'd0);
        check("mrst_data", 64'(data_out_TDATA), 64'd0);
        check("mrst_det", 64'(det_active_V), 64'd0);
        check("mrst_burst", 64'(burst_count_V), 64'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        ready_force = 1'b1;
        @(posedge ap_clk);
        #3;
        clear_trace();
        for (int k = 0; k < 300; k++) send(16'(3 * k), 16'(k + 7));
        drain("post_rst");
        check_trace("post_rst", 300, 1, 256, 0, 0);
        check("post_rst_drop", 64'(drop_count_V), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
